lab7_switch_debounce: RTL and testbench

LAB7_SWITCH_DEBOUNCE -- requirements
Module: lab7_switch_debounce

---
 rtl/lab7_switch_debounce.sv | 89 ++++++++
 tb/tb_lab7_switch_debounce.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab7_switch_debounce.sv
// rtl/lab7_switch_debounce.sv - 18-bit slide-switch debouncer with a shared sample tick
module lab7_switch_debounce #(
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] sw_raw,
    output logic [17:0] sw_stable,
    output logic        sw_changed,
    output logic [17:0] sw_change_mask
);

    localparam int NB = 18;
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);

    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    cnt [NB];
    logic [3:0]    cnt_nxt [NB];
    logic [NB-1:0] stable_nxt;
    logic [NB-1:0] mask_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A bit's count only survives while its synchronized level keeps disagreeing
    // with the accepted level; any agreement restarts it, tick or not.
    always_comb begin
        stable_nxt = sw_stable;
        mask_nxt   = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync2[i] == sw_stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (tick) begin
                if (cnt[i] >= CNT_LAST) begin
                    stable_nxt[i] = sync2[i];
                    mask_nxt[i]   = 1'b1;
                    cnt_nxt[i]    = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_stable      <= '0;
            sw_change_mask <= '0;
            sw_changed     <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_stable      <= stable_nxt;
            sw_change_mask <= mask_nxt;
            sw_changed     <= |mask_nxt;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_lab7_switch_debounce.sv
// tb/tb_lab7_switch_debounce.sv - bench for lab7_switch_debounce (two parameter sets)
module tb_lab7_switch_debounce;

    logic        clk;
    logic        reset_n;
    logic [17:0] sw_raw;
    logic [17:0] stable0, mask0, stable1, mask1;
    logic        chg0, chg1;

    lab7_switch_debounce #(.TICK_DIV(4), .STABLE_CNT(3)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_stable(stable0), .sw_changed(chg0), .sw_change_mask(mask0)
    );

    lab7_switch_debounce #(.TICK_DIV(2), .STABLE_CNT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_stable(stable1), .sw_changed(chg1), .sw_change_mask(mask1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [17:0] raw;
        logic [17:0] stable;
        logic        changed;
        logic [17:0] mask;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a bit is accepted once the synchronized level has
    // disagreed continuously across STABLE_CNT sample ticks.
    int          td_a [2];
    int          sc_a [2];
    int          m_k;
    logic [17:0] hist [$];
    logic [17:0] m_stable [2];
    logic [17:0] m_mask [2];
    int          run_start [2][18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, m_k - 1, act, exp);
        end
    endtask

    function automatic int ticks_in(input int a, input int b, input int td);
        return (b + 1) / td - a / td;
    endfunction

    task automatic model_reset();
        m_k = 0;
        hist.delete();
        for (int j = 0; j < 2; j++) begin
            m_stable[j] = '0;
            m_mask[j]   = '0;
            for (int i = 0; i < 18; i++) run_start[j][i] = -1;
        end
    endtask

    task automatic model_step();
        logic [17:0] s2;
        s2 = (m_k >= 2) ? hist[m_k - 2] : 18'h0;
        hist.push_back(sw_raw);
        for (int j = 0; j < 2; j++) begin
            m_mask[j] = '0;
            for (int i = 0; i < 18; i++) begin
                if (s2[i] == m_stable[j][i]) begin
                    run_start[j][i] = -1;
                end else begin
                    if (run_start[j][i] < 0) run_start[j][i] = m_k;
                    if (ticks_in(run_start[j][i], m_k, td_a[j]) >= sc_a[j]) begin
                        m_stable[j][i]  = s2[i];
                        m_mask[j][i]    = 1'b1;
                        run_start[j][i] = -1;
                    end
                end
            end
        end
        m_k++;
    endtask

    // One clock: sw_raw is already set; outputs are checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model stable0", stable0, m_stable[0]);
        chk("model changed0", chg0, |m_mask[0]);
        chk("model mask0", mask0, m_mask[0]);
        chk("model stable1", stable1, m_stable[1]);
        chk("model changed1", chg1, |m_mask[1]);
        chk("model mask1", mask1, m_mask[1]);
    endtask

    // Called on a falling edge; asserts reset between clock edges.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset stable0", stable0, 18'h0);
        chk("reset changed0", chg0, 1'b0);
        chk("reset mask0", mask0, 18'h0);
        chk("reset stable1", stable1, 18'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    vec_t tbl [$];
    vec_t v;
    int   np, pk;
    logic [17:0] pm;

    initial begin
        td_a[0] = 4; sc_a[0] = 3;
        td_a[1] = 2; sc_a[1] = 1;
        reset_n = 1'b1;
        sw_raw  = '0;
        model_reset();

        for (int c = 0; c < 32; c++) begin
            v.rst     = (c == 0);
            v.raw     = (c < 16) ? 18'h00001 : 18'h0;
            v.changed = (c == 11) || (c == 27);
            v.stable  = (c >= 11 && c < 27) ? 18'h00001 : 18'h0;
            v.mask    = v.changed ? 18'h00001 : 18'h0;
            tbl.push_back(v);
        end
        for (int c = 0; c < 36; c++) begin
            v.rst     = (c == 0);
            v.raw     = (c < 12) ? 18'h3FFFF : 18'h0;
            v.changed = (c == 11) || (c == 23);
            v.stable  = (c >= 11 && c < 23) ? 18'h3FFFF : 18'h0;
            v.mask    = v.changed ? 18'h3FFFF : 18'h0;
            tbl.push_back(v);
        end

        @(negedge clk);
        do_reset();

        for (int c = 0; c < 20; c++) begin
            chk("tick period", u_dut0.tick, (c % 4) == 3);
            cyc();
            chk("idle outputs", {stable0, chg0, mask0}, 37'h0);
        end

        foreach (tbl[n]) begin
            if (tbl[n].rst) do_reset();
            sw_raw = tbl[n].raw;
            cyc();
            chk("vec stable", stable0, tbl[n].stable);
            chk("vec changed", chg0, tbl[n].changed);
            chk("vec mask", mask0, tbl[n].mask);
        end

        // Bounce on bit 5, settling high from edge 12
        do_reset();
        np = 0; pk = -1; pm = '0;
        for (int c = 0; c < 40; c++) begin
            sw_raw = (c < 12) ? ((((c / 3) % 2) == 0) ? 18'h00020 : 18'h0) : 18'h00020;
            cyc();
            if (chg0) begin np++; pk = m_k - 1; pm = mask0; end
        end
        chk("bounce pulses", np, 1);
        chk("bounce edge", pk, 23);
        chk("bounce mask", pm, 18'h00020);
        chk("bounce stable", stable0, 18'h00020);

        // Six-cycle glitch on bit 17
        do_reset();
        np = 0;
        for (int c = 0; c < 30; c++) begin
            sw_raw = (c < 6) ? 18'h20000 : 18'h0;
            cyc();
            if (chg0) np++;
        end
        chk("glitch pulses", np, 0);
        chk("glitch stable", stable0, 18'h0);

        // Reset while an accepted level is held
        do_reset();
        sw_raw = 18'h00001;
        for (int c = 0; c < 14; c++) cyc();
        chk("pre-reset stable", stable0, 18'h00001);
        do_reset();

        // Reset mid-count on bit 2, full latency again afterwards
        sw_raw = 18'h00004;
        np = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (chg0) np++;
        end
        chk("midcount no pulse", np, 0);
        do_reset();
        np = 0; pk = -1; pm = '0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (chg0 && np == 0) begin pk = m_k - 1; pm = mask0; end
            if (chg0) np++;
        end
        chk("restart pulses", np, 1);
        chk("restart edge", pk, 11);
        chk("restart mask", pm, 18'h00004);

        // Random bouncy stimulus against the model, with one reset mid-run
        do_reset();
        sw_raw = '0;
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) do_reset();
            if ($urandom_range(0, 199) == 0) begin
                sw_raw = 18'($urandom);
            end else begin
                for (int i = 0; i < 18; i++) begin
                    if ($urandom_range(0, 39) == 0) sw_raw[i] = ~sw_raw[i];
                end
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
